// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-token words, aligner state encoding and
// the decoder's fixed latency. Used by the decoder, the encoder side and benches.
package tmds_pkg;

   // Control tokens as they appear on the wire (bit 0 transmitted first).
   localparam logic [9:0] TOK_C00 = 10'h354;
   localparam logic [9:0] TOK_C01 = 10'h0AB;
   localparam logic [9:0] TOK_C10 = 10'h154;
   localparam logic [9:0] TOK_C11 = 10'h2AB;

   // Cycles from a symbol on I_tmds_word to its decoded outputs.
   localparam int DEC_LATENCY = 2;

   // Word-alignment state machine.
   typedef enum logic [1:0] {
      ST_SEARCH    = 2'd0,
      ST_SLIP      = 2'd1,
      ST_SLIP_WAIT = 2'd2,
      ST_LOCKED    = 2'd3
   } align_state_e;

   // Classification and decode of one 10-bit symbol.
   typedef struct packed {
      logic       is_ctrl;
      logic [1:0] ctrl;
      logic [7:0] data;
   } sym_t;

endpackage

// File: rtl/tmds_sym_decode.sv
// Combinational TMDS symbol decoder: recognises the four control tokens and
// recovers the 8-bit payload of a data symbol. Holds no state.
module tmds_sym_decode
   import tmds_pkg::*;
(
   input  logic [9:0] word_i,
   output sym_t       sym_o
);

   logic [7:0] d;
   logic [7:0] q;

   // Undo the optional inversion flagged by bit 9.
   assign d = word_i[9] ? ~word_i[7:0] : word_i[7:0];

   // Undo the XOR/XNOR chain selected by bit 8; bit 0 passes straight through.
   assign q[0] = d[0];
   for (genvar gi = 1; gi < 8; gi++) begin : g_chain
      assign q[gi] = word_i[8] ? (d[gi] ^ d[gi-1]) : ~(d[gi] ^ d[gi-1]);
   end

   // Token match; anything that is not one of the four tokens is data.
   always_comb begin
      sym_o.is_ctrl = 1'b1;
      sym_o.ctrl    = 2'b00;
      sym_o.data    = q;
      case (word_i)
         TOK_C00: sym_o.ctrl = 2'b00;
         TOK_C01: sym_o.ctrl = 2'b01;
         TOK_C10: sym_o.ctrl = 2'b10;
         TOK_C11: sym_o.ctrl = 2'b11;
         default: sym_o.is_ctrl = 1'b0;
      endcase
   end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS channel: two-stage symbol decode pipeline plus a word aligner that
// hunts for runs of control tokens and requests deserializer bit-slips until
// the symbol boundary is found. Decoding runs in every state; O_aligned alone
// says whether the outputs can be trusted.
// Optional build macro TMDS_DEC_STATS_EN adds O_relock_cnt, a saturating
// count of lost-lock events.
module tmds_channel_decoder
   import tmds_pkg::*;
#(
   parameter int CTRL_RUN     = 8,
   parameter int WIN_LEN      = 2048,
   parameter int SLIP_WAIT    = 16,
   parameter int LOCK_TIMEOUT = 4096
) (
   input  logic        I_pxl_clk,
   input  logic        I_rst,
   input  logic [9:0]  I_tmds_word,
   output logic        O_bitslip,
   output logic        O_aligned,
   output logic        O_de,
   output logic [1:0]  O_c,
   output logic [7:0]  O_data
`ifdef TMDS_DEC_STATS_EN
   ,
   output logic [15:0] O_relock_cnt
`endif
);

   localparam int RUN_W  = $clog2(CTRL_RUN + 1);
   localparam int WIN_W  = $clog2(WIN_LEN + 1);
   localparam int WAIT_W = $clog2(SLIP_WAIT + 1);
   localparam int TO_W   = $clog2(LOCK_TIMEOUT + 1);

   localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(CTRL_RUN);
   localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WIN_LEN - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);

   // ---------------------------------------------------------------
   // Decode pipeline
   // ---------------------------------------------------------------
   sym_t in_sym;

   // Stage 1: symbol classification. Both flags are 0 straight out of reset
   // so the first real symbol is neither counted twice nor shown as data.
   logic       is_ctrl_q, is_ctrl_d;
   logic       is_data_q, is_data_d;
   logic [1:0] ctrl_q,    ctrl_d;
   logic [7:0] data1_q,   data1_d;

   // Stage 2: output registers.
   logic       de_q,   de_d;
   logic [1:0] c_q,    c_d;
   logic [7:0] data_q, data_d;

   tmds_sym_decode u_sym_decode (
      .word_i (I_tmds_word),
      .sym_o  (in_sym)
   );

   // Stage 1 captures the classification of the incoming word.
   always_comb begin
      is_ctrl_d = in_sym.is_ctrl;
      is_data_d = ~in_sym.is_ctrl;
      ctrl_d    = in_sym.ctrl;
      data1_d   = in_sym.data;
   end

   // Stage 2 forms the channel outputs; control bits hold through data periods.
   always_comb begin
      de_d   = is_data_q;
      c_d    = is_ctrl_q ? ctrl_q : c_q;
      data_d = is_data_q ? data1_q : 8'h00;
   end

   // Pipeline registers.
   always_ff @(posedge I_pxl_clk) begin
      if (I_rst) begin
         is_ctrl_q <= 1'b0;
         is_data_q <= 1'b0;
         ctrl_q    <= 2'b00;
         data1_q   <= 8'h00;
         de_q      <= 1'b0;
         c_q       <= 2'b00;
         data_q    <= 8'h00;
      end else begin
         is_ctrl_q <= is_ctrl_d;
         is_data_q <= is_data_d;
         ctrl_q    <= ctrl_d;
         data1_q   <= data1_d;
         de_q      <= de_d;
         c_q       <= c_d;
         data_q    <= data_d;
      end
   end

   // ---------------------------------------------------------------
   // Word aligner
   // ---------------------------------------------------------------
   align_state_e      state_q, state_d;
   logic [RUN_W-1:0]  run_q,   run_d;
   logic [WIN_W-1:0]  win_q,   win_d;
   logic [WAIT_W-1:0] wait_q,  wait_d;
   logic [TO_W-1:0]   to_q,    to_d;
   logic              run_hit;
   logic              bitslip;
   logic              aligned;

   // Consecutive control-token count; forced to zero around a slip so tokens
   // seen at the old phase cannot contribute to a lock at the new one.
   always_comb begin
      run_d = run_q;
      if (state_q == ST_SLIP || state_q == ST_SLIP_WAIT) begin
         run_d = '0;
      end else if (is_ctrl_q) begin
         run_d = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
      end else if (is_data_q) begin
         run_d = '0;
      end
      run_hit = (run_d == RUN_MAX);
   end

   // Phase-search window, settle timer and lock-timeout counters.
   always_comb begin
      win_d  = (state_q == ST_SEARCH)    ? win_q + 1'b1  : '0;
      wait_d = (state_q == ST_SLIP_WAIT) ? wait_q + 1'b1 : '0;
      to_d   = (state_q == ST_LOCKED && !run_hit) ? to_q + 1'b1 : '0;
   end

   // Counter registers.
   always_ff @(posedge I_pxl_clk) begin
      if (I_rst) begin
         run_q  <= '0;
         win_q  <= '0;
         wait_q <= '0;
         to_q   <= '0;
      end else begin
         run_q  <= run_d;
         win_q  <= win_d;
         wait_q <= wait_d;
         to_q   <= to_d;
      end
   end

   // FSM state register.
   always_ff @(posedge I_pxl_clk) begin
      if (I_rst) begin
         state_q <= ST_SEARCH;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state; a lock found on the last window cycle wins over the slip.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_SEARCH: begin
            if (run_hit) begin
               state_d = ST_LOCKED;
            end else if (win_d == WIN_LAST) begin
               state_d = ST_SLIP;
            end
         end
         ST_SLIP: begin
            state_d = ST_SLIP_WAIT;
         end
         ST_SLIP_WAIT: begin
            if (wait_q == WAIT_LAST) begin
               state_d = ST_SEARCH;
            end
         end
         ST_LOCKED: begin
            if (!run_hit && to_d == TO_LAST) begin
               state_d = ST_SEARCH;
            end
         end
         default: begin
            state_d = ST_SEARCH;
         end
      endcase
   end

   // FSM outputs: the slip request is exactly the one cycle spent in SLIP.
   always_comb begin
      bitslip = (state_q == ST_SLIP);
      aligned = (state_q == ST_LOCKED);
   end

   assign O_bitslip = bitslip;
   assign O_aligned = aligned;
   assign O_de      = de_q;
   assign O_c       = c_q;
   assign O_data    = data_q;

`ifdef TMDS_DEC_STATS_EN
   logic [15:0] relock_q, relock_d;

   // Count every loss of lock, sticking at all-ones.
   always_comb begin
      relock_d = relock_q;
      if (state_q == ST_LOCKED && state_d == ST_SEARCH && relock_q != 16'hFFFF) begin
         relock_d = relock_q + 16'd1;
      end
   end

   // Relock counter register.
   always_ff @(posedge I_pxl_clk) begin
      if (I_rst) begin
         relock_q <= 16'h0000;
      end else begin
         relock_q <= relock_d;
      end
   end

   assign O_relock_cnt = relock_q;
`endif

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Bench for tmds_channel_decoder: random TMDS traffic with a scoreboard on the
// decoded outputs, a rotating deserializer model that honours O_bitslip, and
// cycle-exact checks on the aligner's lock/slip/timeout behaviour.
`timescale 1ns/1ps
module tb_tmds_channel_decoder;

   localparam int CTRL_RUN     = 8;
   localparam int WIN_LEN      = 64;
   localparam int SLIP_WAIT    = 8;
   localparam int LOCK_TIMEOUT = 256;
   localparam int LAT          = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] word = 10'h000;
   logic       bitslip, aligned, de;
   logic [1:0] c;
   logic [7:0] data;
`ifdef TMDS_DEC_STATS_EN
   logic [15:0] relock;
`endif

   always #5 clk = ~clk;

   tmds_channel_decoder #(
      .CTRL_RUN     (CTRL_RUN),
      .WIN_LEN      (WIN_LEN),
      .SLIP_WAIT    (SLIP_WAIT),
      .LOCK_TIMEOUT (LOCK_TIMEOUT)
   ) dut (
      .I_pxl_clk    (clk),
      .I_rst        (rst),
      .I_tmds_word  (word),
      .O_bitslip    (bitslip),
      .O_aligned    (aligned),
      .O_de         (de),
      .O_c          (c),
      .O_data       (data)
`ifdef TMDS_DEC_STATS_EN
      ,
      .O_relock_cnt (relock)
`endif
   );

   typedef struct {
      int         due;
      logic       de;
      logic [1:0] c;
      logic [7:0] data;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   slip_seen = 0;
   int   rot_off = 0;
   logic [1:0] last_c = 2'b00;
   logic [9:0] toks [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

   always @(posedge clk) cyc <= cyc + 1;

   // Deserializer model: each sampled slip pulse rotates the word by one bit.
   always @(posedge clk) if (bitslip) slip_seen <= slip_seen + 1;

   // Returns {is_token, c1, c0} for a wire word.
   function automatic logic [2:0] tok_class(input logic [9:0] w);
      if (w == 10'h354) return 3'b100;
      if (w == 10'h0AB) return 3'b101;
      if (w == 10'h154) return 3'b110;
      if (w == 10'h2AB) return 3'b111;
      return 3'b000;
   endfunction

   // Reference TMDS encoder (transmit side), used to build data symbols.
   function automatic logic [9:0] tmds_enc(input logic [7:0] b, input bit use_xor, input bit inv);
      logic [7:0] qm;
      qm[0] = b[0];
      for (int i = 1; i < 8; i++)
         qm[i] = use_xor ? (qm[i-1] ^ b[i]) : ~(qm[i-1] ^ b[i]);
      return {inv, use_xor, inv ? ~qm : qm};
   endfunction

   task automatic rand_data(output logic [9:0] w, output logic [7:0] b);
      logic [2:0] tc;
      do begin
         b  = 8'($urandom);
         w  = tmds_enc(b, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
         tc = tok_class(w);
      end while (tc[2]);
   endtask

   task automatic set_rot(input int target);
      rot_off = (target - (slip_seen % 10) + 10) % 10;
   endtask

   // Present one symbol for one cycle; optionally queue its expected outputs.
   task automatic drive(input logic [9:0] true_w, input logic [7:0] exp_b, input bit chk);
      logic [19:0] dbl;
      logic [2:0]  tc;
      exp_t        e;
      int          r;
      @(posedge clk);
      #1;
      rst  = 1'b0;
      r    = (rot_off + slip_seen) % 10;
      dbl  = {true_w, true_w} >> (10 - r);
      word = dbl[9:0];
      tc   = tok_class(word);
      if (tc[2]) begin
         last_c = tc[1:0];
         e.de = 1'b0; e.c = tc[1:0]; e.data = 8'h00;
      end else begin
         e.de = 1'b1; e.c = last_c; e.data = exp_b;
      end
      e.due = cyc + LAT;
      if (chk) sb_q.push_back(e);
   endtask

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Scoreboard monitor: compares the DUT outputs against each due expectation.
   always @(negedge clk) begin
      while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
         mon_e = sb_q.pop_front();
         n_cmp++;
         if (mon_e.due != cyc || de !== mon_e.de || c !== mon_e.c || data !== mon_e.data) begin
            n_err++;
            $display("FAIL sb_out: got de=%0b c=%0b data=%02h, expected de=%0b c=%0b data=%02h (due %0d, cycle %0d)",
                     de, c, data, mon_e.de, mon_e.c, mon_e.data, mon_e.due, cyc);
         end else begin
            $display("txn cycle=%0d de=%0b c=%0b data=%02h ok", cyc, de, c, data);
         end
      end
   end

   task automatic do_reset;
      repeat (3) @(posedge clk);
      #1;
      rst    = 1'b1;
      last_c = 2'b00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_bitslip", int'(bitslip), 0);
      check("rst_aligned", int'(aligned), 0);
      check("rst_de",      int'(de),      0);
      check("rst_c",       int'(c),       0);
      check("rst_data",    int'(data),    0);
   endtask

   initial begin
      logic [9:0] w;
      logic [7:0] b;
      int pulses[$];
      int lock_k;
      int t;

      // Lock on a clean token stream from reset.
      do_reset();
      set_rot(0);
      for (int k = 0; k <= CTRL_RUN + 3; k++) begin
         drive(10'h354, 8'h00, 1'b1);
         @(negedge clk);
         check("lock_rise", int'(aligned), (k >= CTRL_RUN + 1) ? 1 : 0);
         check("lock_noslip", int'(bitslip), 0);
      end

      // Known data symbol, then a token, then random bursts while locked.
      drive(tmds_enc(8'hA5, 1'b1, 1'b1), 8'hA5, 1'b1);
      drive(10'h2AB, 8'h00, 1'b1);
      for (int burst = 0; burst < 10; burst++) begin
         for (int i = 0; i < 20; i++) begin
            rand_data(w, b);
            drive(w, b, 1'b1);
         end
         for (int i = 0; i < 10; i++) drive(toks[$urandom_range(0, 3)], 8'h00, 1'b1);
         @(negedge clk);
         check("burst_locked", int'(aligned), 1);
      end

      // Only data symbols while locked: lock drops on cycle LOCK_TIMEOUT.
      for (int k = 0; k < LOCK_TIMEOUT + 3; k++) begin
         rand_data(w, b);
         drive(w, b, 1'b1);
         @(negedge clk);
         check("timeout", int'(aligned), (k < LOCK_TIMEOUT) ? 1 : 0);
      end
`ifdef TMDS_DEC_STATS_EN
      check("relock_cnt", int'(relock), 1);
`endif

      // Run completes on the last window cycle: lock, no slip.
      do_reset();
      set_rot(0);
      t = WIN_LEN - CTRL_RUN - 2;
      for (int k = 0; k <= WIN_LEN + 4; k++) begin
         if (k < t) begin
            rand_data(w, b);
            drive(w, b, 1'b1);
         end else begin
            drive(toks[$urandom_range(0, 3)], 8'h00, 1'b1);
         end
         @(negedge clk);
         check("edge_lock", int'(aligned), (k >= WIN_LEN - 1) ? 1 : 0);
         check("edge_noslip", int'(bitslip), 0);
      end

      // One cycle later the window wins: slip, no lock.
      do_reset();
      set_rot(0);
      for (int k = 0; k <= WIN_LEN + 2; k++) begin
         if (k < t + 1) begin
            rand_data(w, b);
            drive(w, b, 1'b1);
         end else begin
            drive(10'h154, 8'h00, (k <= WIN_LEN - 1) ? 1'b1 : 1'b0);
         end
         @(negedge clk);
         check("late_slip", int'(bitslip), (k == WIN_LEN - 1) ? 1 : 0);
         check("late_nolock", int'(aligned), 0);
      end

      // Stream rotated by 3 bits: seven slips bring it back to phase 0.
      do_reset();
      set_rot(3);
      lock_k = -1;
      for (int k = 0; k < 20000; k++) begin
         drive(10'h354, 8'h00, 1'b0);
         @(negedge clk);
         if (bitslip) pulses.push_back(k);
         if (aligned) begin
            lock_k = k;
            break;
         end
      end
      check("rot_locked", (lock_k >= 0) ? 1 : 0, 1);
      check("rot_slips", pulses.size(), 7);
      check("rot_phase", (rot_off + slip_seen) % 10, 0);
      if (pulses.size() > 0) begin
         check("rot_first", pulses[0], WIN_LEN - 1);
         check("rot_lock_at", lock_k, pulses[pulses.size()-1] + SLIP_WAIT + 1 + CTRL_RUN);
      end
      for (int i = 1; i < pulses.size(); i++) begin
         check("rot_gap_min", (pulses[i] - pulses[i-1] >= WIN_LEN + SLIP_WAIT) ? 1 : 0, 1);
         check("rot_gap_max", (pulses[i] - pulses[i-1] <= WIN_LEN + SLIP_WAIT + 1) ? 1 : 0, 1);
      end
      for (int i = 0; i < 4; i++) drive(toks[i], 8'h00, 1'b1);
      rand_data(w, b);
      drive(w, b, 1'b1);

      // Reset landing on the slip pulse cycle.
      do_reset();
      set_rot(5);
      t = -1;
      for (int k = 0; k < 2 * WIN_LEN; k++) begin
         drive(10'h354, 8'h00, 1'b0);
         @(negedge clk);
         if (bitslip) begin
            t = k;
            break;
         end
      end
      check("rs_first_slip", t, WIN_LEN - 1);
      rst    = 1'b1;
      last_c = 2'b00;
      drive(10'h354, 8'h00, 1'b0);
      @(negedge clk);
      check("rs_bitslip", int'(bitslip), 0);
      check("rs_aligned", int'(aligned), 0);
      check("rs_de",      int'(de),      0);
      check("rs_c",       int'(c),       0);
      check("rs_data",    int'(data),    0);
      for (int k = 1; k <= WIN_LEN + 2; k++) begin
         drive(10'h354, 8'h00, 1'b0);
         @(negedge clk);
         check("rs_restart", int'(bitslip), (k == WIN_LEN - 1) ? 1 : 0);
      end

      repeat (4) @(posedge clk);
      @(negedge clk);
      check("sb_drained", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
